// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with run-time pattern reload and overlap control.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               COUNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       din,
   input  logic                       overlap_en,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   input  logic                       cnt_clr,
   output logic                       detect,
   output logic [$clog2(PAT_W+1)-1:0] fill,
   output logic [COUNT_W-1:0]         match_cnt
);

   localparam int                FILL_W   = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  pat_r;
   logic [PAT_W-1:0]  hist_r;
   logic [FILL_W-1:0] fill_r;
   logic              detect_r;
   logic [PAT_W-1:0]  nh_s;
   logic              hit_s;

   // next history word and match qualification for the bit offered this cycle
   always_comb begin
      nh_s  = {hist_r[PAT_W-2:0], din};
      hit_s = 1'b0;
      if (en && !pat_load && !rst) begin
         hit_s = (fill_r >= FILL_THR) && (nh_s == pat_r);
      end else begin
         hit_s = 1'b0;
      end
   end

   // pattern, history, fill and detect state
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_r    <= PATTERN;
         hist_r   <= {PAT_W{1'b0}};
         fill_r   <= {FILL_W{1'b0}};
         detect_r <= 1'b0;
      end else if (pat_load) begin
         pat_r    <= pat_in;
         hist_r   <= {PAT_W{1'b0}};
         fill_r   <= {FILL_W{1'b0}};
         detect_r <= 1'b0;
      end else if (en) begin
         hist_r   <= nh_s;
         detect_r <= hit_s;
         // a non-overlapping hit consumes its bits, so the next match starts from scratch
         if (hit_s && !overlap_en) begin
            fill_r <= {FILL_W{1'b0}};
         end else if (fill_r != FILL_MAX) begin
            fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
         end else begin
            fill_r <= fill_r;
         end
      end else begin
         detect_r <= 1'b0;
      end
   end

   assign detect = detect_r;
   assign fill   = fill_r;

`ifdef SEQDET_COUNT_EN
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   logic [COUNT_W-1:0] cnt_r;

   // saturating hit counter; a clear wins over a simultaneous hit
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {COUNT_W{1'b0}};
      end else if (cnt_clr) begin
         cnt_r <= {COUNT_W{1'b0}};
      end else if (hit_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign match_cnt = cnt_r;
`else
   logic unused_cnt_clr_s;

   assign unused_cnt_clr_s = cnt_clr;
   assign match_cnt        = {COUNT_W{1'b0}};
`endif

endmodule
